fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_INIT, default 32'h00000000, is the word-aligned PC loaded at reset.
REQ-002 CLK  in  1  clock; all state updates on the rising edge.
REQ-003 RST  in  1  reset; synchronous and active-high.
REQ-004 ihit  in  1  instruction memory returns imemload this cycle.
REQ-005 imemload  in  32  instruction word from memory.
REQ-006 imemREN  out  1  instruction read request.
REQ-007 imemaddr  out  32  instruction read address; equals current PC.
REQ-008 stall  in  1  IF/ID register not accepting (the hazard unit drives IF/ID EN low).
REQ-009 redirect  in  1  taken branch or jump resolved downstream.
REQ-010 redirect_pc  in  32  redirect target.
REQ-011 halt  in  1  halt reached write-back; stops fetch.
REQ-012 instr_o  out  32  fetched instruction, drives IF/ID instr_i.
REQ-013 npc_o  out  32  PC+4 of instr_o, drives IF/ID npc_i.
REQ-014 valid_o  out  1  instr_o/npc_o valid; IF/ID flush = !valid_o.

Function
REQ-015 The block SHALL keep a 32-bit PC register and a state register with states FETCH, HOLD and HALTED.
REQ-016 In FETCH: imemREN=1 and imemaddr=PC; in HOLD and HALTED: imemREN=0.
REQ-017 In FETCH: valid_o = ihit & !redirect, instr_o = imemload and npc_o = PC+4, all combinational with zero-cycle latency.
REQ-018 In FETCH, when ihit & !stall & !redirect, the block SHALL load PC with PC+4 at the next edge.
REQ-019 In FETCH, when ihit & stall, the block SHALL hold PC; the skid behaviour is set by REQ-028 and REQ-029.
REQ-020 In FETCH, when ihit=0, the block SHALL hold PC and state, keep imemREN asserted and drive valid_o=0.
REQ-021 redirect SHALL take priority over stall and ihit in every state except HALTED: PC <= {redirect_pc[31:2],2'b00}, state <= FETCH, any held instruction discarded, valid_o=0 in that cycle.
REQ-022 halt SHALL take priority over redirect: state <= HALTED and valid_o=0 from the same cycle; PC is frozen.
REQ-023 HALTED SHALL be left only by RST.
REQ-024 PC arithmetic SHALL be modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000.
REQ-025 The two low bits of PC SHALL always be zero.

Reset
REQ-026 On RST=1 at an edge, the block SHALL set PC=PC_INIT, state=FETCH and clear the skid register; RST SHALL override all other inputs.
REQ-027 Outputs after reset SHALL be imemREN=1, imemaddr=PC_INIT, valid_o=0 until the first ihit, and instr_o=npc_o=0 whenever valid_o=0.

Configuration
REQ-028 With FETCH_SKID_EN defined: on ihit & stall in FETCH, the block SHALL capture imemload into a one-entry skid register and enter HOLD. In HOLD it SHALL drive valid_o=1, instr_o=skid and npc_o=PC+4. When stall=0, it SHALL set PC <= PC+4 and return to FETCH.
REQ-029 Without FETCH_SKID_EN: HOLD SHALL be unreachable and no skid register SHALL exist. On ihit & stall the block SHALL stay in FETCH and re-request the same PC, so the instruction is re-fetched next cycle.

Structure
REQ-030 The fetch_state_t enum (FETCH, HOLD, HALTED) and the PC_STEP=4 constant SHALL live in cpu_types_pkg.
REQ-031 The skid storage SHALL be one sub-module, fetch_skid (load, clear, data), instantiated only under FETCH_SKID_EN.

Verification
REQ-032 Reset with PC_INIT=0 and ihit=1 every cycle, no stall -> imemaddr sequence 0,4,8,C; valid_o=1 each cycle; npc_o=4,8,C,10.
REQ-033 At PC=8 hold ihit=0 for 3 cycles, then ihit=1 -> imemaddr stays 8 for 4 cycles; valid_o=0 for 3 cycles, then 1; PC then becomes C.
REQ-034 At PC=10 assert stall for 2 cycles with ihit=1:
- skid build: one request, then imemREN=0 for the remaining stall cycle, valid_o=1 with the same instr_o throughout, PC=14 after stall drops;
- non-skid build: imemaddr=10 for 3 cycles, then 14.
REQ-035 At PC=20 assert redirect with redirect_pc=32'h00000103 together with ihit & stall -> valid_o=0 that cycle; next imemaddr=32'h00000100; skid cleared.
REQ-036 Assert halt and redirect in the same cycle -> state HALTED, imemREN=0, valid_o=0 held for 5 further cycles; RST then restores imemaddr=PC_INIT.
REQ-037 Redirect to 32'hFFFFFFFC with ihit=1 and no stall -> next imemaddr=32'h00000000, npc_o=32'h00000000 in the FFFFFFFC cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: fetch state encoding, PC step and word-alignment helper
package cpu_types_pkg;
  typedef enum logic [1:0] {FETCH, HOLD, HALTED} fetch_state_t;
  localparam logic [31:0] PC_STEP = 32'd4;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry holding register for an instruction the decode stage could not accept
module fetch_skid (
  input  logic        clk,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);
  logic [31:0] r_data;
  always_ff @(posedge clk) r_data <= i_clear ? '0 : (i_load ? i_data : r_data);
  assign o_data = r_data;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and instruction fetch FSM (FETCH/HOLD/HALTED)
// FETCH_SKID_EN: when defined, a stalled hit is parked in fetch_skid instead of being re-fetched
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr_o,
  output logic [31:0] npc_o,
  output logic        valid_o
);
  logic [31:0] r_pc, w_pc_next, w_pc_inc, w_skid;
  fetch_state_t r_state, w_state_next;
  logic w_live;
`ifdef FETCH_SKID_EN
  localparam bit SKID = 1'b1;
  logic w_load;
  assign w_load = (r_state == FETCH) && (w_state_next == HOLD);
  fetch_skid u_skid (
    .clk    (CLK),
    .i_clear(RST | (redirect & (r_state != HALTED))),
    .i_load (w_load),
    .i_data (imemload),
    .o_data (w_skid)
  );
`else
  localparam bit SKID = 1'b0;
  assign w_skid = '0;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc    <= word_align(PC_INIT);
      r_state <= FETCH;
    end else begin
      r_pc    <= w_pc_next;
      r_state <= w_state_next;
    end
  end
  // halt outranks redirect, which outranks stall/ihit; HALTED only exits via RST
  always_comb begin
    w_pc_inc     = r_pc + PC_STEP;
    w_pc_next    = r_pc;
    w_state_next = r_state;
    if (r_state != HALTED) begin
      if (halt) w_state_next = HALTED;
      else if (redirect) begin
        w_pc_next    = word_align(redirect_pc);
        w_state_next = FETCH;
      end else if (r_state == FETCH) begin
        if (ihit && !stall) w_pc_next = w_pc_inc;
        else if (ihit) w_state_next = SKID ? HOLD : FETCH;
      end else if (!stall) begin
        w_pc_next    = w_pc_inc;
        w_state_next = FETCH;
      end
    end
  end
  assign imemREN  = (r_state == FETCH);
  assign imemaddr = r_pc;
  assign w_live   = (r_state != HALTED) && !halt && !redirect;
  assign valid_o  = w_live && ((r_state == HOLD) || ((r_state == FETCH) && ihit));
  assign instr_o  = !valid_o ? '0 : (r_state == HOLD ? w_skid : imemload);
  assign npc_o    = valid_o ? w_pc_inc : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit (follows FETCH_SKID_EN if defined)
module tb_fetch_unit;
  logic        CLK = 1'b0, RST = 1'b1, ihit = 1'b0, stall = 1'b0, redirect = 1'b0, halt = 1'b0;
  logic [31:0] imemload = '0, redirect_pc = '0;
  logic        imemREN, valid_o;
  logic [31:0] imemaddr, instr_o, npc_o;
  typedef struct {logic [31:0] instr; logic [31:0] npc;} exp_t;
  exp_t sb[$];
  int n_checks = 0, n_fail = 0;

  fetch_unit #(.PC_INIT(32'h00000000)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .imemREN(imemREN),
    .imemaddr(imemaddr), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .instr_o(instr_o), .npc_o(npc_o), .valid_o(valid_o)
  );

  always #5 CLK = ~CLK;

  task automatic drive(input bit ih, st, rd, input logic [31:0] rp, input bit hl, input logic [31:0] ld);
    @(posedge CLK);
    #1;
    RST = 1'b0; ihit = ih; stall = st; redirect = rd; redirect_pc = rp; halt = hl; imemload = ld;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1; ihit = 1'b1; stall = 1'b1; redirect = 1'b1; halt = 1'b1;
    redirect_pc = 32'h00000444; imemload = 32'hDEADBEEF;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, 0, 0, 0, 32'h12345678);
    n_checks++;
    if (imemREN !== 1'b1 || imemaddr !== 32'h0 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got ren=%b addr=%h valid=%b want ren=1 addr=00000000 valid=0", imemREN, imemaddr, valid_o);
    end
    n_checks++;
    if (instr_o !== 32'h0 || npc_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data got instr=%h npc=%h want 0/0", instr_o, npc_o);
    end
  endtask

  task automatic test_sequential();
    exp_t e;
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w = 32'hA0000000 + 32'(i);
      sb.push_back('{w, 32'(4 * (i + 1))});
      drive(1, 0, 0, 0, 0, w);
      n_checks++;
      if (imemaddr !== 32'(4 * i) || imemREN !== 1'b1 || valid_o !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_ctrl[%0d] got addr=%h ren=%b valid=%b want addr=%h ren=1 valid=1", i, imemaddr, imemREN, valid_o, 4 * i);
      end
      e = sb.pop_front();
      n_checks++;
      if (instr_o !== e.instr || npc_o !== e.npc) begin
        n_fail++;
        $display("FAIL seq_data[%0d] got instr=%h npc=%h want instr=%h npc=%h", i, instr_o, npc_o, e.instr, e.npc);
      end
    end
  endtask

  task automatic test_miss();
    exp_t e;
    do_reset();
    drive(1, 0, 0, 0, 0, 32'h11111111);
    drive(1, 0, 0, 0, 0, 32'h22222222);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 32'hBADBAD00);
      n_checks++;
      if (imemaddr !== 32'h8 || imemREN !== 1'b1 || valid_o !== 1'b0 || instr_o !== 32'h0) begin
        n_fail++;
        $display("FAIL miss_wait[%0d] got addr=%h ren=%b valid=%b instr=%h want addr=00000008 ren=1 valid=0 instr=0", i, imemaddr, imemREN, valid_o, instr_o);
      end
    end
    sb.push_back('{32'h33333333, 32'hC});
    drive(1, 0, 0, 0, 0, 32'h33333333);
    e = sb.pop_front();
    n_checks++;
    if (imemaddr !== 32'h8 || valid_o !== 1'b1 || instr_o !== e.instr || npc_o !== e.npc) begin
      n_fail++;
      $display("FAIL miss_hit got addr=%h valid=%b instr=%h npc=%h want addr=00000008 valid=1 instr=%h npc=%h", imemaddr, valid_o, instr_o, npc_o, e.instr, e.npc);
    end
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (imemaddr !== 32'hC) begin
      n_fail++;
      $display("FAIL miss_next got addr=%h want 0000000c", imemaddr);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    do_reset();
    drive(1, 0, 1, 32'h10, 0, 32'h0);
    sb.push_back('{32'h5A5A0010, 32'h14});
    for (int i = 0; i < 3; i++) begin
`ifdef FETCH_SKID_EN
      drive(i == 0, i < 2, 0, 0, 0, i == 0 ? 32'h5A5A0010 : 32'hFFFF0000);
      n_checks++;
      if (imemaddr !== 32'h10 || imemREN !== (i == 0)) begin
        n_fail++;
        $display("FAIL stall_ctrl[%0d] got addr=%h ren=%b want addr=00000010 ren=%b", i, imemaddr, imemREN, i == 0);
      end
`else
      drive(1, i < 2, 0, 0, 0, 32'h5A5A0010);
      n_checks++;
      if (imemaddr !== 32'h10 || imemREN !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_ctrl[%0d] got addr=%h ren=%b want addr=00000010 ren=1", i, imemaddr, imemREN);
      end
`endif
      e = sb[0];
      n_checks++;
      if (valid_o !== 1'b1 || instr_o !== e.instr || npc_o !== e.npc) begin
        n_fail++;
        $display("FAIL stall_data[%0d] got valid=%b instr=%h npc=%h want valid=1 instr=%h npc=%h", i, valid_o, instr_o, npc_o, e.instr, e.npc);
      end
      if (!stall) void'(sb.pop_front());
    end
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (imemaddr !== 32'h14 || imemREN !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_next got addr=%h ren=%b want addr=00000014 ren=1", imemaddr, imemREN);
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    do_reset();
    drive(1, 0, 1, 32'h20, 0, 32'h77777777);
    n_checks++;
    if (valid_o !== 1'b0 || instr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL redir_first got valid=%b instr=%h want valid=0 instr=0", valid_o, instr_o);
    end
    drive(1, 1, 1, 32'h103, 0, 32'h66666666);
    n_checks++;
    if (imemaddr !== 32'h20 || valid_o !== 1'b0 || instr_o !== 32'h0 || npc_o !== 32'h0) begin
      n_fail++;
      $display("FAIL redir_stall got addr=%h valid=%b instr=%h npc=%h want addr=00000020 valid=0 instr=0 npc=0", imemaddr, valid_o, instr_o, npc_o);
    end
    drive(0, 1, 0, 0, 0, 32'h0);
    n_checks++;
    if (imemaddr !== 32'h100 || imemREN !== 1'b1 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_target got addr=%h ren=%b valid=%b want addr=00000100 ren=1 valid=0", imemaddr, imemREN, valid_o);
    end
    sb.push_back('{32'h44444444, 32'h104});
    drive(1, 0, 0, 0, 0, 32'h44444444);
    e = sb.pop_front();
    n_checks++;
    if (valid_o !== 1'b1 || instr_o !== e.instr || npc_o !== e.npc) begin
      n_fail++;
      $display("FAIL redir_fetch got valid=%b instr=%h npc=%h want valid=1 instr=%h npc=%h", valid_o, instr_o, npc_o, e.instr, e.npc);
    end
  endtask

  task automatic test_halt();
    do_reset();
    drive(1, 0, 1, 32'h40, 0, 32'h1);
    drive(1, 0, 1, 32'h80, 1, 32'h2);
    n_checks++;
    if (valid_o !== 1'b0 || instr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL halt_entry got valid=%b instr=%h want valid=0 instr=0", valid_o, instr_o);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 32'hC0, 0, 32'h3);
      n_checks++;
      if (imemREN !== 1'b0 || valid_o !== 1'b0 || imemaddr !== 32'h40 || npc_o !== 32'h0) begin
        n_fail++;
        $display("FAIL halt_hold[%0d] got ren=%b valid=%b addr=%h npc=%h want ren=0 valid=0 addr=00000040 npc=0", i, imemREN, valid_o, imemaddr, npc_o);
      end
    end
    do_reset();
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (imemaddr !== 32'h0 || imemREN !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_reset got addr=%h ren=%b want addr=00000000 ren=1", imemaddr, imemREN);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    do_reset();
    drive(1, 0, 1, 32'hFFFFFFFC, 0, 32'h0);
    sb.push_back('{32'hCAFEF00D, 32'h0});
    drive(1, 0, 0, 0, 0, 32'hCAFEF00D);
    e = sb.pop_front();
    n_checks++;
    if (imemaddr !== 32'hFFFFFFFC || valid_o !== 1'b1 || instr_o !== e.instr || npc_o !== e.npc) begin
      n_fail++;
      $display("FAIL wrap_top got addr=%h valid=%b instr=%h npc=%h want addr=fffffffc valid=1 instr=%h npc=%h", imemaddr, valid_o, instr_o, npc_o, e.instr, e.npc);
    end
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (imemaddr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_next got addr=%h want 00000000", imemaddr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_miss();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
